// File: rtl/voice_scheduler.sv
// -----------------------------------------------------------------------------
// voice_scheduler
//
// Purpose:
//   Accepts note events on a valid/ready handshake and hands each one to a
//   free note_player voice. Every accepted event walks IDLE -> LOAD -> SETTLE.
//   During LOAD the chosen voice gets a one-cycle load strobe, and the shared
//   note/duration buses carry the registered event. SETTLE blocks acceptance
//   for one more cycle so that the voice has time to take the load. Rest
//   events (note 0) and zero-duration events pass through the same three
//   states but never strobe a voice.
//
// Configuration:
//   VOICE_SCHEDULER_STEAL_EN - when defined, an event arriving while every
//   voice is busy steals the voice holding the oldest 2-bit age stamp (lowest
//   index on a tie). When undefined, ev_ready stays low until a voice frees,
//   and no age logic is built.
//
// Ports:
//   clk              in   system clock, all state on the rising edge
//   reset_n          in   asynchronous active-low reset
//   play_enable      in   global gate; low blocks new acceptances only
//   ev_valid         in   note event offered
//   ev_note[5:0]     in   note index, 0 = rest
//   ev_duration[5:0] in   duration in beats
//   ev_ready         out  event taken on a cycle with ev_valid && ev_ready
//   done_with_note   in   per-voice completion pulses
//   load_new_note    out  one-hot one-cycle load strobe per voice
//   note_to_load     out  registered note, shared by all voices
//   duration_to_load out  registered duration, shared by all voices
//   voice_busy       out  per-voice occupancy flags
//   active_count     out  number of busy voices
//   idle             out  high in IDLE with no voice busy
// -----------------------------------------------------------------------------
module voice_scheduler #(
  parameter int NUM_VOICES = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  play_enable,
  input  logic                  ev_valid,
  input  logic [5:0]            ev_note,
  input  logic [5:0]            ev_duration,
  output logic                  ev_ready,
  input  logic [NUM_VOICES-1:0] done_with_note,
  output logic [NUM_VOICES-1:0] load_new_note,
  output logic [5:0]            note_to_load,
  output logic [5:0]            duration_to_load,
  output logic [NUM_VOICES-1:0] voice_busy,
  output logic [2:0]            active_count,
  output logic                  idle
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [5:0]              note_q, note_d;
  logic [5:0]              dur_q, dur_d;
  logic [1:0]              target_q, target_d;
  // Set when the latched event really plays (non-rest, non-zero duration).
  logic                    real_q, real_d;
  logic [NUM_VOICES-1:0]   busy_q, busy_d;

  logic                    any_free;
  logic [1:0]              free_idx;
  logic                    voice_avail;
  logic [1:0]              target_sel;
  logic                    accept;
  logic [NUM_VOICES-1:0]   target_onehot;

  // ---------------------------------------------------------------------------
  // Lowest-index free voice. Scanning downwards lets the lowest index win.
  // ---------------------------------------------------------------------------
  always_comb begin
    any_free = 1'b0;
    free_idx = 2'd0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!busy_q[v]) begin
        any_free = 1'b1;
        free_idx = 2'(v);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_onehot
      assign target_onehot[gi] = (target_q == 2'(gi));
    end
  endgenerate

`ifdef VOICE_SCHEDULER_STEAL_EN
  // ---------------------------------------------------------------------------
  // Voice stealing. Each voice remembers the load counter value at its last
  // real load. Relative age is (counter - stamp - 1) mod 4, so the most recent
  // load reads 0, and a stamp equal to the counter (four loads back) reads 3,
  // which is the oldest.
  // ---------------------------------------------------------------------------
  logic [1:0]                  cnt_q;
  logic [NUM_VOICES-1:0][1:0]  age_q;
  logic [NUM_VOICES-1:0][1:0]  age_rel;
  logic [1:0]                  oldest_idx;
  logic [1:0]                  oldest_rel;

  for (gi = 0; gi < NUM_VOICES; gi++) begin : g_age_rel
    assign age_rel[gi] = cnt_q - age_q[gi] - 2'd1;
  end

  // A strict greater-than keeps the lowest index on a tie.
  always_comb begin
    oldest_idx = 2'd0;
    oldest_rel = age_rel[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age_rel[v] > oldest_rel) begin
        oldest_rel = age_rel[v];
        oldest_idx = 2'(v);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 2'd0;
      age_q <= '0;
    end else if (load_new_note != '0) begin
      cnt_q <= cnt_q + 2'd1;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (load_new_note[v]) begin
          age_q[v] <= cnt_q;
        end
      end
    end
  end

  assign voice_avail = 1'b1;
  assign target_sel  = any_free ? free_idx : oldest_idx;
`else
  assign voice_avail = any_free;
  assign target_sel  = free_idx;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      note_q   <= 6'd0;
      dur_q    <= 6'd0;
      target_q <= 2'd0;
      real_q   <= 1'b0;
      busy_q   <= '0;
    end else begin
      state_q  <= state_d;
      note_q   <= note_d;
      dur_q    <= dur_d;
      target_q <= target_d;
      real_q   <= real_d;
      busy_q   <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    note_d        = note_q;
    dur_d         = dur_q;
    target_d      = target_q;
    real_d        = real_q;
    ev_ready      = 1'b0;
    load_new_note = '0;
    accept        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Gating with reset_n keeps ready low while reset is held.
        ev_ready = reset_n && play_enable && voice_avail;
        accept   = ev_valid && ev_ready;
        if (accept) begin
          state_d  = ST_LOAD;
          note_d   = ev_note;
          dur_d    = ev_duration;
          target_d = target_sel;
          real_d   = (ev_note != 6'd0) && (ev_duration != 6'd0);
        end
      end
      ST_LOAD: begin
        // Driven from state: an asynchronous reset removes the strobe at once.
        if (real_q) begin
          load_new_note = target_onehot;
        end
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Completion clears busy. A load in the same cycle wins over a completion.
  // A completion on an idle voice changes nothing.
  assign busy_d = (busy_q & ~done_with_note) | load_new_note;

  always_comb begin
    active_count = 3'd0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      active_count = active_count + {2'b00, busy_q[v]};
    end
  end

  assign note_to_load     = note_q;
  assign duration_to_load = dur_q;
  assign voice_busy       = busy_q;
  assign idle             = (state_q == ST_IDLE) && (busy_q == '0);

endmodule

// File: tb/tb_voice_scheduler.sv
module tb_voice_scheduler;

  localparam int NV = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          play_enable;
  logic          ev_valid;
  logic [5:0]    ev_note;
  logic [5:0]    ev_duration;
  logic          ev_ready;
  logic [NV-1:0] done_with_note;
  logic [NV-1:0] load_new_note;
  logic [5:0]    note_to_load;
  logic [5:0]    duration_to_load;
  logic [NV-1:0] voice_busy;
  logic [2:0]    active_count;
  logic          idle;

  int checks = 0;
  int errors = 0;

  voice_scheduler #(.NUM_VOICES(NV)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .play_enable      (play_enable),
    .ev_valid         (ev_valid),
    .ev_note          (ev_note),
    .ev_duration      (ev_duration),
    .ev_ready         (ev_ready),
    .done_with_note   (done_with_note),
    .load_new_note    (load_new_note),
    .note_to_load     (note_to_load),
    .duration_to_load (duration_to_load),
    .voice_busy       (voice_busy),
    .active_count     (active_count),
    .idle             (idle)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs, then let combinational outputs settle before sampling.
  task automatic drive(input logic v, input logic [5:0] n, input logic [5:0] d,
                       input logic [NV-1:0] dn);
    ev_valid       = v;
    ev_note        = n;
    ev_duration    = d;
    done_with_note = dn;
    #1;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    play_enable = 1'b1;
    drive(1'b0, 6'd0, 6'd0, '0);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  // Bring one event through the whole handshake; returns in IDLE.
  task automatic play_one(input logic [5:0] n, input logic [5:0] d);
    drive(1'b1, n, d, '0);
    tick();
    drive(1'b0, 6'd0, 6'd0, '0);
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    play_enable = 1'b1;
    drive(1'b1, 6'd5, 6'd5, '0);
    tick();
    checks++; if (ev_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ev_ready); end
    checks++; if (load_new_note !== 3'b000) begin errors++; $display("FAIL reset_load: got %b want 000", load_new_note); end
    checks++; if (note_to_load !== 6'd0) begin errors++; $display("FAIL reset_note: got %0d want 0", note_to_load); end
    checks++; if (duration_to_load !== 6'd0) begin errors++; $display("FAIL reset_dur: got %0d want 0", duration_to_load); end
    checks++; if (voice_busy !== 3'b000) begin errors++; $display("FAIL reset_busy: got %b want 000", voice_busy); end
    checks++; if (active_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", active_count); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", idle); end
    drive(1'b0, 6'd0, 6'd0, '0);
    reset_n = 1'b1;
    #1;
    checks++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", ev_ready); end
  endtask

  task automatic test_basic_load();
    do_reset();
    play_enable = 1'b0;
    drive(1'b1, 6'd12, 6'd4, '0);
    checks++; if (ev_ready !== 1'b0) begin errors++; $display("FAIL gate_ready: got %b want 0", ev_ready); end
    tick();
    checks++; if (load_new_note !== 3'b000) begin errors++; $display("FAIL gate_load: got %b want 000", load_new_note); end
    play_enable = 1'b1;
    #1;
    checks++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", ev_ready); end
    tick();
    $display("txn accept note=12 dur=4");
    drive(1'b0, 6'd0, 6'd0, '0);
    checks++; if (load_new_note !== 3'b001) begin errors++; $display("FAIL basic_load: got %b want 001", load_new_note); end
    checks++; if (note_to_load !== 6'd12) begin errors++; $display("FAIL basic_note: got %0d want 12", note_to_load); end
    checks++; if (duration_to_load !== 6'd4) begin errors++; $display("FAIL basic_dur: got %0d want 4", duration_to_load); end
    tick();
    checks++; if (load_new_note !== 3'b000) begin errors++; $display("FAIL basic_strobe_len: got %b want 000", load_new_note); end
    checks++; if (voice_busy !== 3'b001) begin errors++; $display("FAIL basic_busy: got %b want 001", voice_busy); end
    checks++; if (active_count !== 3'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", active_count); end
    checks++; if (ev_ready !== 1'b0) begin errors++; $display("FAIL basic_settle_ready: got %b want 0", ev_ready); end
    tick();
    checks++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_back: got %b want 1", ev_ready); end
  endtask

  task automatic test_back_to_back();
    int n_acc;
    int load_cyc [NV];
    logic [NV-1:0] load_mask [NV];
    logic acc;
    do_reset();
    n_acc = 0;
    for (int v = 0; v < NV; v++) begin load_cyc[v] = -1; load_mask[v] = '0; end
    for (int c = 0; c < 10; c++) begin
      drive(n_acc < NV, 6'(10 + n_acc), 6'd3, '0);
      acc = ev_valid && ev_ready;
      if (load_new_note != '0) begin
        for (int v = 0; v < NV; v++) begin
          if (load_cyc[v] < 0) begin load_cyc[v] = c; load_mask[v] = load_new_note; break; end
        end
      end
      tick();
      if (acc) begin $display("txn accept note=%0d cycle=%0d", 10 + n_acc, c); n_acc++; end
    end
    for (int v = 0; v < NV; v++) begin
      checks++; if (load_cyc[v] !== 1 + 3 * v) begin errors++; $display("FAIL b2b_cycle%0d: got %0d want %0d", v, load_cyc[v], 1 + 3 * v); end
      checks++; if (load_mask[v] !== NV'(1 << v)) begin errors++; $display("FAIL b2b_mask%0d: got %b want %b", v, load_mask[v], NV'(1 << v)); end
    end
    checks++; if (voice_busy !== 3'b111) begin errors++; $display("FAIL b2b_busy: got %b want 111", voice_busy); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", idle); end
    checks++; if (active_count !== 3'd3) begin errors++; $display("FAIL b2b_count: got %0d want 3", active_count); end
  endtask

  // Runs straight after test_back_to_back, with all three voices busy.
  task automatic test_all_busy();
`ifdef VOICE_SCHEDULER_STEAL_EN
    drive(1'b1, 6'd20, 6'd5, '0);
    checks++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL steal_ready: got %b want 1", ev_ready); end
    tick();
    $display("txn accept note=20 (steal)");
    drive(1'b0, 6'd0, 6'd0, '0);
    checks++; if (load_new_note !== 3'b001) begin errors++; $display("FAIL steal_load: got %b want 001", load_new_note); end
    checks++; if (note_to_load !== 6'd20) begin errors++; $display("FAIL steal_note: got %0d want 20", note_to_load); end
    tick();
    checks++; if (voice_busy !== 3'b111) begin errors++; $display("FAIL steal_busy: got %b want 111", voice_busy); end
    tick();
`else
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 6'd20, 6'd5, '0);
      checks++; if (ev_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d: got %b want 0", c, ev_ready); end
      tick();
      checks++; if (load_new_note !== 3'b000) begin errors++; $display("FAIL bp_load%0d: got %b want 000", c, load_new_note); end
    end
    drive(1'b1, 6'd20, 6'd5, 3'b010);
    tick();
    drive(1'b1, 6'd20, 6'd5, '0);
    checks++; if (voice_busy !== 3'b101) begin errors++; $display("FAIL bp_freed: got %b want 101", voice_busy); end
    checks++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b want 1", ev_ready); end
    tick();
    $display("txn accept note=20 (after free)");
    drive(1'b0, 6'd0, 6'd0, '0);
    checks++; if (load_new_note !== 3'b010) begin errors++; $display("FAIL bp_load: got %b want 010", load_new_note); end
    checks++; if (note_to_load !== 6'd20) begin errors++; $display("FAIL bp_note: got %0d want 20", note_to_load); end
    tick();
    checks++; if (voice_busy !== 3'b111) begin errors++; $display("FAIL bp_busy: got %b want 111", voice_busy); end
    tick();
`endif
  endtask

  task automatic test_done_same_cycle();
    do_reset();
    drive(1'b1, 6'd5, 6'd3, '0);
    tick();
    $display("txn accept note=5 with done collision");
    drive(1'b0, 6'd0, 6'd0, 3'b001);
    checks++; if (load_new_note !== 3'b001) begin errors++; $display("FAIL coll_load: got %b want 001", load_new_note); end
    tick();
    drive(1'b0, 6'd0, 6'd0, '0);
    checks++; if (voice_busy !== 3'b001) begin errors++; $display("FAIL coll_busy: got %b want 001", voice_busy); end
    tick();
    drive(1'b0, 6'd0, 6'd0, 3'b101);
    tick();
    drive(1'b0, 6'd0, 6'd0, '0);
    checks++; if (voice_busy !== 3'b000) begin errors++; $display("FAIL done_clear: got %b want 000", voice_busy); end
  endtask

  task automatic test_rest();
    do_reset();
    play_one(6'd7, 6'd2);
    drive(1'b1, 6'd0, 6'd8, '0);
    checks++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL rest_ready: got %b want 1", ev_ready); end
    tick();
    $display("txn accept rest dur=8");
    drive(1'b0, 6'd0, 6'd0, '0);
    checks++; if (load_new_note !== 3'b000) begin errors++; $display("FAIL rest_load: got %b want 000", load_new_note); end
    checks++; if (duration_to_load !== 6'd8) begin errors++; $display("FAIL rest_dur: got %0d want 8", duration_to_load); end
    checks++; if (ev_ready !== 1'b0) begin errors++; $display("FAIL rest_ready_load: got %b want 0", ev_ready); end
    tick();
    checks++; if (ev_ready !== 1'b0) begin errors++; $display("FAIL rest_ready_settle: got %b want 0", ev_ready); end
    checks++; if (voice_busy !== 3'b001) begin errors++; $display("FAIL rest_busy: got %b want 001", voice_busy); end
    tick();
    checks++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL rest_ready_back: got %b want 1", ev_ready); end
    drive(1'b1, 6'd9, 6'd0, '0);
    tick();
    $display("txn accept note=9 dur=0");
    drive(1'b0, 6'd0, 6'd0, '0);
    checks++; if (load_new_note !== 3'b000) begin errors++; $display("FAIL zdur_load: got %b want 000", load_new_note); end
    tick();
    tick();
    checks++; if (voice_busy !== 3'b001) begin errors++; $display("FAIL zdur_busy: got %b want 001", voice_busy); end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    drive(1'b1, 6'd33, 6'd7, '0);
    tick();
    $display("txn accept note=33 then reset");
    drive(1'b0, 6'd0, 6'd0, '0);
    checks++; if (load_new_note !== 3'b001) begin errors++; $display("FAIL rml_pre: got %b want 001", load_new_note); end
    reset_n = 1'b0;
    #1;
    checks++; if (load_new_note !== 3'b000) begin errors++; $display("FAIL rml_load: got %b want 000", load_new_note); end
    checks++; if (note_to_load !== 6'd0) begin errors++; $display("FAIL rml_note: got %0d want 0", note_to_load); end
    checks++; if (duration_to_load !== 6'd0) begin errors++; $display("FAIL rml_dur: got %0d want 0", duration_to_load); end
    checks++; if (ev_ready !== 1'b0) begin errors++; $display("FAIL rml_ready: got %b want 0", ev_ready); end
    #1;
    reset_n = 1'b1;
    tick();
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rml_idle: got %b want 1", idle); end
    checks++; if (voice_busy !== 3'b000) begin errors++; $display("FAIL rml_busy: got %b want 000", voice_busy); end
  endtask

  // Reference model: per-voice busy flags, a count of cycles still blocked
  // after an accept (2 = strobe cycle, 1 = settle cycle), and the order in
  // which voices were last loaded.
  task automatic test_random();
    int m_busy [NV];
    int m_seq  [NV];
    int m_total, m_block, m_pending;
    logic [5:0] m_note, m_dur;
    logic v;
    logic [5:0] n, d;
    logic [NV-1:0] dn, e_busy, e_load;
    logic e_ready;
    int e_count, tgt, best;
    do_reset();
    for (int i = 0; i < NV; i++) begin m_busy[i] = 0; m_seq[i] = 0; end
    m_total = 0; m_block = 0; m_pending = -1; m_note = 0; m_dur = 0;
    for (int c = 0; c < 400; c++) begin
      play_enable = ($urandom % 10) != 0;
      v  = $urandom % 2;
      n  = ($urandom % 4 == 0) ? 6'd0 : 6'($urandom % 64);
      d  = ($urandom % 6 == 0) ? 6'd0 : 6'($urandom % 64);
      dn = '0;
      for (int i = 0; i < NV; i++) dn[i] = ($urandom % 8) == 0;
      drive(v, n, d, dn);

      tgt = -1;
      for (int i = NV - 1; i >= 0; i--) if (m_busy[i] == 0) tgt = i;
`ifdef VOICE_SCHEDULER_STEAL_EN
      if (tgt < 0) begin
        best = -1;
        for (int i = 0; i < NV; i++) begin
          if (((m_total - 1 - m_seq[i]) % 4 + 4) % 4 > best) begin
            best = ((m_total - 1 - m_seq[i]) % 4 + 4) % 4;
            tgt  = i;
          end
        end
      end
`endif
      e_ready = (m_block == 0) && play_enable && (tgt >= 0);
      e_load  = '0;
      if (m_block == 2 && m_pending >= 0) e_load[m_pending] = 1'b1;
      e_busy  = '0;
      e_count = 0;
      for (int i = 0; i < NV; i++) begin e_busy[i] = m_busy[i] != 0; e_count += m_busy[i]; end

      checks++; if (ev_ready !== e_ready) begin errors++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, ev_ready, e_ready); end
      checks++; if (load_new_note !== e_load) begin errors++; $display("FAIL rnd_load c=%0d: got %b want %b", c, load_new_note, e_load); end
      checks++; if (note_to_load !== m_note) begin errors++; $display("FAIL rnd_note c=%0d: got %0d want %0d", c, note_to_load, m_note); end
      checks++; if (duration_to_load !== m_dur) begin errors++; $display("FAIL rnd_dur c=%0d: got %0d want %0d", c, duration_to_load, m_dur); end
      checks++; if (voice_busy !== e_busy) begin errors++; $display("FAIL rnd_busy c=%0d: got %b want %b", c, voice_busy, e_busy); end
      checks++; if (active_count !== 3'(e_count)) begin errors++; $display("FAIL rnd_count c=%0d: got %0d want %0d", c, active_count, e_count); end
      checks++; if (idle !== ((m_block == 0) && (e_count == 0))) begin errors++; $display("FAIL rnd_idle c=%0d: got %b want %b", c, idle, (m_block == 0) && (e_count == 0)); end

      for (int i = 0; i < NV; i++) if (dn[i]) m_busy[i] = 0;
      if (m_block == 2 && m_pending >= 0) begin
        m_busy[m_pending] = 1;
        m_seq[m_pending]  = m_total;
        m_total++;
      end
      if (v && e_ready) begin
        $display("txn accept c=%0d note=%0d dur=%0d voice=%0d", c, n, d, tgt);
        m_note    = n;
        m_dur     = d;
        m_pending = (n != 0 && d != 0) ? tgt : -1;
        m_block   = 2;
      end else if (m_block > 0) begin
        m_block--;
      end
      tick();
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    play_enable    = 1'b0;
    ev_valid       = 1'b0;
    ev_note        = 6'd0;
    ev_duration    = 6'd0;
    done_with_note = '0;
    test_reset();
    test_basic_load();
    test_back_to_back();
    test_all_busy();
    test_done_same_cycle();
    test_rest();
    test_reset_mid_load();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/voice_scheduler.md
VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 Parameter NUM_VOICES, default 3, number of note_player voices driven (legal 1..4).
REQ-002 clk  in  1  single system clock; all state on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 play_enable  in  1  global play gate; low blocks new acceptances; forwarded unchanged to voices.
REQ-005 ev_valid  in  1  note event offered.
REQ-006 ev_note  in  6  note index (0 = rest).
REQ-007 ev_duration  in  6  duration in beats.
REQ-008 ev_ready  out  1  event accepted on cycle where ev_valid && ev_ready.
REQ-009 done_with_note  in  NUM_VOICES  per-voice completion pulse from each note_player.
REQ-010 load_new_note  out  NUM_VOICES  one-hot, one-cycle load strobe per voice.
REQ-011 note_to_load  out  6  registered note, shared bus to all voices.
REQ-012 duration_to_load  out  6  registered duration, shared bus.
REQ-013 voice_busy  out  NUM_VOICES  per-voice occupancy flags.
REQ-014 active_count  out  3  number of set voice_busy bits.
REQ-015 idle  out  1  high when state IDLE and voice_busy all zero.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, SETTLE; IDLE->LOAD on accept, LOAD->SETTLE unconditionally, SETTLE->IDLE unconditionally.
REQ-017 ev_ready SHALL be high only in IDLE, with play_enable high, and a voice available (free voice, or any voice if stealing compiled in).
REQ-018 On accept, ev_note/ev_duration SHALL be registered into note_to_load/duration_to_load and target voice latched.
REQ-019 Target voice SHALL be lowest-index voice with voice_busy clear.
REQ-020 In LOAD, load_new_note SHALL pulse high for exactly one cycle on target voice only (latency: one cycle after accept).
REQ-021 In LOAD, target voice_busy SHALL be set; if done_with_note for same voice is high that cycle, set wins.
REQ-022 Rest events (ev_note == 0) or ev_duration == 0 SHALL be accepted, produce no load strobe, set no busy bit, still traverse LOAD and SETTLE.
REQ-023 voice_busy[v] SHALL clear on any cycle done_with_note[v] is high, except per REQ-021.
REQ-024 Each voice SHALL hold a 2-bit age stamp from a wrapping 2-bit load counter incremented per real load; age comparison SHALL be modulo-4 relative to counter.
REQ-025 SETTLE SHALL block acceptance for one cycle to cover note_player load latency.
REQ-026 active_count SHALL be a combinational popcount of voice_busy.
REQ-027 play_enable deasserting SHALL NOT alter voice_busy or abort LOAD/SETTLE.
REQ-028 done_with_note on a non-busy voice SHALL be ignored.

Reset
REQ-029 While reset_n low: state IDLE, load_new_note 0, note_to_load 0, duration_to_load 0, voice_busy 0, age stamps 0, load counter 0, ev_ready 0.
REQ-030 Reset asserted mid-LOAD SHALL suppress the strobe immediately (asynchronous).
REQ-031 After reset_n rises, ev_ready SHALL follow REQ-017 from the first clock edge.

Configuration
REQ-032 Macro VOICE_SCHEDULER_STEAL_EN defined: when all voices busy, accept SHALL proceed and target the voice with oldest age stamp (lowest index on tie); busy stays set.
REQ-033 Macro undefined: when all voices busy, ev_ready SHALL stay low until a voice frees (backpressure); no age logic compiled.

Verification
REQ-034 Reset, play_enable=1, event note 12 dur 4 -> ev_ready high, load_new_note=3'b001 one cycle later, note_to_load=12, duration_to_load=4, voice_busy=3'b001, active_count=1.
REQ-035 Three back-to-back events -> loads on voices 0,1,2 each 3 cycles apart; voice_busy=3'b111; idle=0.
REQ-036 All busy, fourth event note 20: STEAL_EN -> voice 0 reloaded with 20; without -> ev_ready low until done_with_note[1] pulses, then voice 1 loaded.
REQ-037 done_with_note[0] and load of voice 0 same cycle -> voice_busy[0] remains 1.
REQ-038 Rest event note 0 dur 8 -> accepted, no load strobe, voice_busy unchanged, ev_ready returns after 2 cycles.
REQ-039 reset_n pulsed low during LOAD -> load_new_note drops same cycle, all outputs at reset values, idle high after release.
